// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller.
package mem_access_ctrl_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10
    } state_e;

    // Access size codes; 2'b11 is also treated as a word
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    // Default number of BUSY cycles allowed before an access is aborted
    localparam int unsigned TimeoutDefault = 15;

    // Natural alignment: bytes anywhere, halfwords on even, words on 4-byte boundaries
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SizeByte: ok = 1'b1;
            SizeHalf: ok = ~addr_lo[0];
            default:  ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Load result extension: picks the low byte/halfword/word and sign- or zero-extends it.
module mem_load_ext
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  size,
    input  logic        se,
    output logic [31:0] result
);

    // Select and extend the right-justified read data
    always_comb begin
        result = data;
        case (size)
            SizeByte: result = {{24{se & data[7]}}, data[7:0]};
            SizeHalf: result = {{16{se & data[15]}}, data[15:0]};
            default:  result = data;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: alignment check, request issue,
// ack wait with timeout, load extension and pipeline stall generation.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_enable_in,
    input  logic        mem_rw_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_se_in,
    input  logic [8:0]  addr_in,
    input  logic [31:0] wdata_in,
    output logic        dm_req,
    output logic        dm_rw,
    output logic [1:0]  dm_size,
    output logic [8:0]  dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] rdata_out,
    output logic        rdata_valid,
    output logic        stall,
    output logic        misalign_err,
    output logic        timeout_err
);

    // Counter only needs to reach TIMEOUT-1
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e            state_q;
    logic [CntW-1:0]   wait_cnt_q;
    logic              req_se_q;
    logic              aligned;
    logic [31:0]       ext_data;

    assign aligned = is_aligned(mem_size_in, addr_in[1:0]);

    // Hold the pipeline while accepting a request and for the whole BUSY phase
    assign stall = ((state_q == StIdle) && mem_enable_in && aligned) || (state_q == StBusy);

    mem_load_ext u_load_ext (
        .data   (dm_rdata),
        .size   (dm_size),
        .se     (req_se_q),
        .result (ext_data)
    );

    // Access FSM with registered request, result and error pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            req_se_q     <= 1'b0;
            dm_req       <= 1'b0;
            dm_rw        <= 1'b0;
            dm_size      <= 2'b00;
            dm_addr      <= '0;
            dm_wdata     <= '0;
            rdata_out    <= '0;
            rdata_valid  <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            rdata_valid  <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (mem_enable_in) begin
                        if (aligned) begin
                            state_q    <= StBusy;
                            wait_cnt_q <= '0;
                            dm_req     <= 1'b1;
                            dm_rw      <= mem_rw_in;
                            dm_size    <= mem_size_in;
                            req_se_q   <= mem_se_in;
                            dm_addr    <= addr_in;
                            dm_wdata   <= wdata_in;
                        end else begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                StBusy: begin
                    // Ack takes priority over an expiring timeout
                    if (dm_ack) begin
                        state_q <= StDone;
                        dm_req  <= 1'b0;
                        if (!dm_rw) begin
                            rdata_out   <= ext_data;
                            rdata_valid <= 1'b1;
                        end
                    end else if (wait_cnt_q == CntLast) begin
                        state_q     <= StDone;
                        dm_req      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
